// File: rtl/comm_pkg.sv
// Message types, scheduler states and payload packers shared by the
// game logic, the link scheduler and ChipInterface.
package comm_pkg;

   localparam int MSG_PAYLOAD_W = 24;

   typedef enum logic [2:0] {
      MSG_NONE      = 3'd0,
      BALL          = 3'd1,
      MISS          = 3'd2,
      NEW_GAME      = 3'd3,
      NEW_GAME_ACK  = 3'd4,
      ARE_YOU_THERE = 3'd5,
      I_AM_HERE     = 3'd6,
      I_LOST        = 3'd7
   } msg_type_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ARM      = 3'd1,
      TX_BUSY  = 3'd2,
      TX_DONE  = 3'd3,
      WAIT_ACK = 3'd4,
      DONE     = 3'd5,
      FAIL     = 3'd6
   } tx_state_t;

   // Replies (ACK, presence answer, loss notice) are fire-and-forget.
   function automatic logic needs_ack(input msg_type_t t);
      case (t)
         BALL, MISS, NEW_GAME, ARE_YOU_THERE: needs_ack = 1'b1;
         default:                             needs_ack = 1'b0;
      endcase
   endfunction

   function automatic logic [MSG_PAYLOAD_W-1:0] pack_ball(
      input logic [9:0] ball_y,
      input logic [6:0] speed,
      input logic [6:0] angle
   );
      pack_ball = {ball_y, speed, angle};
   endfunction

   function automatic logic [MSG_PAYLOAD_W-1:0] pack_miss(
      input logic [7:0] score_self,
      input logic [7:0] score_other,
      input logic [7:0] serve_count
   );
      pack_miss = {score_self, score_other, serve_count};
   endfunction

endpackage

// File: rtl/message_tx_scheduler_if.sv
// Link between the scheduler (master) and CommunicationSender plus the
// receiver's ack strobe (slave side).
interface message_tx_scheduler_if
   import comm_pkg::*;
#(
   parameter int PAYLOAD_W = 24
) ();

   logic                 send_new_message;
   logic                 message_sent;
   logic                 message_acked;
   msg_type_t            tx_type;
   logic [PAYLOAD_W-1:0] tx_payload;

   modport master (
      output send_new_message,
      output tx_type,
      output tx_payload,
      input  message_sent,
      input  message_acked
   );

   modport slave (
      input  send_new_message,
      input  tx_type,
      input  tx_payload,
      output message_sent,
      output message_acked
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr,
// wrapping around.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               valid,
   output logic [IDX_W-1:0]   winner
);

   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest hit is written last.
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (req[cand]) begin
            valid  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/message_tx_scheduler.sv
// Shares the CommunicationSender link among game-logic requesters:
// round-robin grant, send handshake, ack wait with timeout and retransmit.
module message_tx_scheduler
   import comm_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int PAYLOAD_W   = 24,
   parameter  int ACK_TIMEOUT = 500_000,
   parameter  int MAX_RETRIES = 3,
   localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int ACK_W       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1,
   localparam int RTY_W       = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req,
   input  logic [NUM_REQ-1:0][2:0]           req_type,
   input  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] req_payload,
   output logic [NUM_REQ-1:0]                req_done,
   output logic [NUM_REQ-1:0]                req_fail,
   message_tx_scheduler_if.master            link,
   output logic                              busy,
   output logic [IDX_W-1:0]                  grant_idx
);

   localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

   tx_state_t            state, state_n;
   logic [IDX_W-1:0]     rr_ptr;
   msg_type_t            tx_type_r;
   logic [PAYLOAD_W-1:0] tx_payload_r;
   logic [RTY_W-1:0]     retry_cnt;
   logic [ACK_W-1:0]     ack_cnt;

   logic                 arb_valid;
   logic [IDX_W-1:0]     arb_winner;
   logic                 load_grant;
   logic                 arm_retry;
   logic                 start_ack;
   logic                 finish;
   logic                 send_pulse;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req    (req),
      .rr_ptr (rr_ptr),
      .valid  (arb_valid),
      .winner (arb_winner)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n    = state;
      load_grant = 1'b0;
      arm_retry  = 1'b0;
      start_ack  = 1'b0;
      finish     = 1'b0;
      send_pulse = 1'b0;
      case (state)
         IDLE: begin
            if (arb_valid) begin
               load_grant = 1'b1;
               state_n    = ARM;
            end
         end
         ARM: begin
            if (link.message_sent) begin
               send_pulse = 1'b1;
               state_n    = TX_BUSY;
            end
         end
         TX_BUSY: begin
            if (!link.message_sent) state_n = TX_DONE;
         end
         TX_DONE: begin
            if (link.message_sent) begin
               if (needs_ack(tx_type_r)) begin
                  start_ack = 1'b1;
                  state_n   = WAIT_ACK;
               end else begin
                  state_n = DONE;
               end
            end
         end
         // An ack landing on the timeout cycle still counts as delivered.
         WAIT_ACK: begin
            if (link.message_acked) begin
               state_n = DONE;
            end else if (ack_cnt == ACK_LAST) begin
               if (retry_cnt < RTY_LIMIT) begin
                  arm_retry = 1'b1;
                  state_n   = ARM;
               end else begin
                  state_n = FAIL;
               end
            end
         end
         DONE, FAIL: begin
            finish  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         grant_idx    <= '0;
         tx_type_r    <= MSG_NONE;
         tx_payload_r <= '0;
         retry_cnt    <= '0;
         ack_cnt      <= '0;
         rr_ptr       <= '0;
      end else begin
         if (load_grant) begin
            grant_idx    <= arb_winner;
            tx_type_r    <= msg_type_t'(req_type[arb_winner]);
            tx_payload_r <= req_payload[arb_winner];
            retry_cnt    <= '0;
         end
         if (arm_retry) retry_cnt <= retry_cnt + 1'b1;
         if (start_ack)               ack_cnt <= '0;
         else if (state == WAIT_ACK)  ack_cnt <= ack_cnt + 1'b1;
         if (finish) rr_ptr <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
      end
   end

   // Pulses are masked during reset so an aborted transfer never reports.
   always_comb begin
      req_done = '0;
      req_fail = '0;
      if (!reset) begin
         if (state == DONE) req_done[grant_idx] = 1'b1;
         if (state == FAIL) req_fail[grant_idx] = 1'b1;
      end
   end

   assign link.send_new_message = send_pulse & ~reset;
   assign link.tx_type          = tx_type_r;
   assign link.tx_payload       = tx_payload_r;
   assign busy                  = (state != IDLE);

endmodule

// File: tb/tb_message_tx_scheduler.sv
// Directed bench for message_tx_scheduler with a simple sender model
// (busy for three cycles after each start pulse).
module tb_message_tx_scheduler;
   import comm_pkg::*;

   localparam int NUM_REQ     = 4;
   localparam int PAYLOAD_W   = 24;
   localparam int ACK_TIMEOUT = 8;
   localparam int MAX_RETRIES = 2;

   logic                              clock = 1'b0;
   logic                              reset = 1'b1;
   logic [NUM_REQ-1:0]                req;
   logic [NUM_REQ-1:0][2:0]           req_type;
   logic [NUM_REQ-1:0][PAYLOAD_W-1:0] req_payload;
   logic [NUM_REQ-1:0]                req_done;
   logic [NUM_REQ-1:0]                req_fail;
   logic                              busy;
   logic [1:0]                        grant_idx;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int n_send = 0;
   int n_done [NUM_REQ] = '{default: 0};
   int n_fail [NUM_REQ] = '{default: 0};
   int snd_cnt = 0;

   message_tx_scheduler_if #(.PAYLOAD_W(PAYLOAD_W)) link ();

   message_tx_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .PAYLOAD_W   (PAYLOAD_W),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .MAX_RETRIES (MAX_RETRIES)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .req_type    (req_type),
      .req_payload (req_payload),
      .req_done    (req_done),
      .req_fail    (req_fail),
      .link        (link),
      .busy        (busy),
      .grant_idx   (grant_idx)
   );

   always #5 clock = ~clock;

   assign link.message_sent = (snd_cnt == 0);

   always @(posedge clock) begin
      if (reset)                      snd_cnt <= 0;
      else if (link.send_new_message) snd_cnt <= 3;
      else if (snd_cnt != 0)          snd_cnt <= snd_cnt - 1;
   end

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (link.send_new_message === 1'b1) n_send = n_send + 1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_done[i] === 1'b1) n_done[i] = n_done[i] + 1;
         if (req_fail[i] === 1'b1) n_fail[i] = n_fail[i] + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // kind 0: send pulse, 1: req_done[idx], 2: req_fail[idx]
   task automatic wait_ev(input int kind, input int idx, input int budget,
                          output bit ok, output int at);
      ok = 1'b0;
      at = 0;
      for (int k = 0; k < budget && !ok; k++) begin
         tick();
         case (kind)
            0:       ok = (link.send_new_message === 1'b1);
            1:       ok = (req_done[idx] === 1'b1);
            default: ok = (req_fail[idx] === 1'b1);
         endcase
         at = cyc;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (link.send_new_message !== 1'b0 || req_done !== 4'b0 || req_fail !== 4'b0) begin
         errors++;
         $display("FAIL reset_pulses: send=%b done=%b fail=%b, expected all 0", link.send_new_message, req_done, req_fail);
      end
      checks++;
      if (busy !== 1'b0 || grant_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_busy_grant: busy=%b grant=%0d, expected 0/0", busy, grant_idx);
      end
      checks++;
      if (link.tx_type !== MSG_NONE || link.tx_payload !== 24'h0) begin
         errors++;
         $display("FAIL reset_tx: type=%0d payload=%h, expected 0/000000", link.tx_type, link.tx_payload);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || link.send_new_message !== 1'b0 || dut.rr_ptr !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: busy=%b send=%b rr_ptr=%0d, expected 0/0/0", busy, link.send_new_message, dut.rr_ptr);
      end
   endtask

   task automatic test_single_no_ack();
      bit ok;
      int t0, ts, td, d0, f0;
      d0 = n_done[2];
      f0 = n_fail[2];
      req_type[2]    = I_AM_HERE;
      req_payload[2] = 24'h123456;
      req[2]         = 1'b1;
      t0 = cyc;
      checks++;
      if (link.send_new_message !== 1'b0) begin
         errors++;
         $display("FAIL single_send_early: send=%b in IDLE cycle, expected 0", link.send_new_message);
      end
      wait_ev(0, 2, 10, ok, ts);
      checks++;
      if (!ok || ts - t0 != 1) begin
         errors++;
         $display("FAIL single_latency: seen=%0b after %0d cycles, expected send 1 cycle after the IDLE cycle", ok, ts - t0);
      end
      checks++;
      if (grant_idx !== 2'd2 || link.tx_type !== I_AM_HERE || link.tx_payload !== 24'h123456 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_latch: grant=%0d type=%0d payload=%h busy=%b, expected 2/6/123456/1", grant_idx, link.tx_type, link.tx_payload, busy);
      end
      wait_ev(1, 2, 20, ok, td);
      req[2] = 1'b0;
      checks++;
      if (!ok || td - ts != 5) begin
         errors++;
         $display("FAIL single_done_time: seen=%0b at +%0d, expected done 5 cycles after send", ok, td - ts);
      end
      tick();
      checks++;
      if (dut.rr_ptr !== 2'd3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_rr_ptr: rr_ptr=%0d busy=%b, expected 3/0", dut.rr_ptr, busy);
      end
      tick();
      tick();
      checks++;
      if (n_done[2] - d0 != 1 || n_fail[2] - f0 != 0) begin
         errors++;
         $display("FAIL single_pulses: done=%0d fail=%0d, expected 1/0", n_done[2] - d0, n_fail[2] - f0);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      int ts, td;
      req_type[0]    = NEW_GAME_ACK;
      req_payload[0] = 24'h000111;
      req_type[3]    = I_LOST;
      req_payload[3] = 24'h333000;
      req[0]         = 1'b1;
      req[3]         = 1'b1;
      wait_ev(0, 0, 10, ok, ts);
      checks++;
      if (!ok || grant_idx !== 2'd0 || link.tx_payload !== 24'h000111 || link.tx_type !== NEW_GAME_ACK) begin
         errors++;
         $display("FAIL simul_first: seen=%0b grant=%0d payload=%h type=%0d, expected 1/0/000111/4", ok, grant_idx, link.tx_payload, link.tx_type);
      end
      wait_ev(1, 0, 20, ok, td);
      req[0] = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL simul_done0: req_done[0] not seen, expected a pulse");
      end
      wait_ev(0, 3, 10, ok, ts);
      checks++;
      if (!ok || ts - td != 2 || grant_idx !== 2'd3 || link.tx_payload !== 24'h333000 || link.tx_type !== I_LOST) begin
         errors++;
         $display("FAIL simul_second: seen=%0b gap=%0d grant=%0d payload=%h type=%0d, expected 1/2/3/333000/7", ok, ts - td, grant_idx, link.tx_payload, link.tx_type);
      end
      wait_ev(1, 3, 20, ok, td);
      req[3] = 1'b0;
      tick();
      checks++;
      if (!ok || dut.rr_ptr !== 2'd0) begin
         errors++;
         $display("FAIL simul_done3: seen=%0b rr_ptr=%0d, expected 1/0", ok, dut.rr_ptr);
      end
   endtask

   task automatic test_ack_arrives();
      bit ok;
      int ts, s0, d0, f0;
      s0 = n_send;
      d0 = n_done[1];
      f0 = n_fail[1];
      req_type[1]    = BALL;
      req_payload[1] = 24'h00A5C3;
      req[1]         = 1'b1;
      wait_ev(0, 1, 10, ok, ts);
      checks++;
      if (!ok || link.tx_type !== BALL || link.tx_payload !== 24'h00A5C3 || grant_idx !== 2'd1) begin
         errors++;
         $display("FAIL ack_send: seen=%0b type=%0d payload=%h grant=%0d, expected 1/1/00a5c3/1", ok, link.tx_type, link.tx_payload, grant_idx);
      end
      repeat (8) tick();
      checks++;
      if (busy !== 1'b1 || link.send_new_message !== 1'b0 || req_done[1] !== 1'b0) begin
         errors++;
         $display("FAIL ack_waiting: busy=%b send=%b done=%b, expected 1/0/0", busy, link.send_new_message, req_done[1]);
      end
      link.message_acked = 1'b1;
      tick();
      link.message_acked = 1'b0;
      checks++;
      if (req_done[1] !== 1'b1) begin
         errors++;
         $display("FAIL ack_done: req_done[1]=%b, expected 1", req_done[1]);
      end
      req[1] = 1'b0;
      repeat (15) tick();
      checks++;
      if (n_send - s0 != 1 || n_done[1] - d0 != 1 || n_fail[1] - f0 != 0) begin
         errors++;
         $display("FAIL ack_counts: sends=%0d done=%0d fail=%0d, expected 1/1/0", n_send - s0, n_done[1] - d0, n_fail[1] - f0);
      end
   endtask

   task automatic test_no_ack();
      bit ok;
      int t1, t2, t3, tf, s0, d0, f0;
      s0 = n_send;
      d0 = n_done[3];
      f0 = n_fail[3];
      req_type[3]    = MISS;
      req_payload[3] = 24'h5A5A5A;
      req[3]         = 1'b1;
      wait_ev(0, 3, 10, ok, t1);
      checks++;
      if (!ok || link.tx_payload !== 24'h5A5A5A) begin
         errors++;
         $display("FAIL noack_send1: seen=%0b payload=%h, expected 1/5a5a5a", ok, link.tx_payload);
      end
      wait_ev(0, 3, 20, ok, t2);
      checks++;
      if (!ok || t2 - t1 != 13 || link.tx_payload !== 24'h5A5A5A || link.tx_type !== MISS) begin
         errors++;
         $display("FAIL noack_send2: seen=%0b gap=%0d payload=%h type=%0d, expected 1/13/5a5a5a/2", ok, t2 - t1, link.tx_payload, link.tx_type);
      end
      wait_ev(0, 3, 20, ok, t3);
      checks++;
      if (!ok || t3 - t2 != 13 || link.tx_payload !== 24'h5A5A5A) begin
         errors++;
         $display("FAIL noack_send3: seen=%0b gap=%0d payload=%h, expected 1/13/5a5a5a", ok, t3 - t2, link.tx_payload);
      end
      wait_ev(2, 3, 20, ok, tf);
      req[3] = 1'b0;
      checks++;
      if (!ok || tf - t3 != 13) begin
         errors++;
         $display("FAIL noack_fail_time: seen=%0b at +%0d, expected fail 13 cycles after last send", ok, tf - t3);
      end
      repeat (15) tick();
      checks++;
      if (n_send - s0 != 3 || n_fail[3] - f0 != 1 || n_done[3] - d0 != 0) begin
         errors++;
         $display("FAIL noack_counts: sends=%0d fail=%0d done=%0d, expected 3/1/0", n_send - s0, n_fail[3] - f0, n_done[3] - d0);
      end
   endtask

   task automatic test_stale_ack();
      int s0, d0;
      s0 = n_send;
      d0 = n_done[0];
      req_type[0]        = ARE_YOU_THERE;
      req_payload[0]     = 24'h0000AA;
      req[0]             = 1'b1;
      link.message_acked = 1'b1;
      tick();
      link.message_acked = 1'b0;
      checks++;
      if (link.send_new_message !== 1'b1 || grant_idx !== 2'd0) begin
         errors++;
         $display("FAIL stale_idle_ack: send=%b grant=%0d, expected 1/0", link.send_new_message, grant_idx);
      end
      tick();
      link.message_acked = 1'b1;
      tick();
      link.message_acked = 1'b0;
      repeat (10) tick();
      checks++;
      if (n_done[0] - d0 != 0 || busy !== 1'b1 || n_send - s0 != 1) begin
         errors++;
         $display("FAIL stale_busy_ack: done=%0d busy=%b sends=%0d, expected 0/1/1", n_done[0] - d0, busy, n_send - s0);
      end
      link.message_acked = 1'b1;
      tick();
      link.message_acked = 1'b0;
      checks++;
      if (req_done[0] !== 1'b1 || link.send_new_message !== 1'b0) begin
         errors++;
         $display("FAIL stale_timeout_ack: done=%b send=%b, expected 1/0", req_done[0], link.send_new_message);
      end
      req[0] = 1'b0;
      repeat (15) tick();
      checks++;
      if (n_send - s0 != 1 || n_done[0] - d0 != 1) begin
         errors++;
         $display("FAIL stale_counts: sends=%0d done=%0d, expected 1/1", n_send - s0, n_done[0] - d0);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int ts, s0, d0, f0;
      s0 = n_send;
      d0 = n_done[2];
      f0 = n_fail[2];
      req_type[2]    = BALL;
      req_payload[2] = 24'h777777;
      req[2]         = 1'b1;
      wait_ev(0, 2, 10, ok, ts);
      repeat (6) tick();
      checks++;
      if (!ok || busy !== 1'b1) begin
         errors++;
         $display("FAIL rmid_in_wait: seen=%0b busy=%b, expected 1/1", ok, busy);
      end
      reset  = 1'b1;
      req[2] = 1'b0;
      #1;
      checks++;
      if (link.send_new_message !== 1'b0 || req_done !== 4'b0 || req_fail !== 4'b0) begin
         errors++;
         $display("FAIL rmid_reset_cycle: send=%b done=%b fail=%b, expected 0", link.send_new_message, req_done, req_fail);
      end
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || grant_idx !== 2'd0 || link.tx_type !== MSG_NONE || link.tx_payload !== 24'h0 ||
          link.send_new_message !== 1'b0 || req_done !== 4'b0 || req_fail !== 4'b0) begin
         errors++;
         $display("FAIL rmid_after: busy=%b grant=%0d type=%0d payload=%h send=%b done=%b fail=%b, expected all 0",
                  busy, grant_idx, link.tx_type, link.tx_payload, link.send_new_message, req_done, req_fail);
      end
      tick();
      checks++;
      if (link.send_new_message !== 1'b0 || dut.rr_ptr !== 2'd0) begin
         errors++;
         $display("FAIL rmid_next: send=%b rr_ptr=%0d, expected 0/0", link.send_new_message, dut.rr_ptr);
      end
      repeat (15) tick();
      checks++;
      if (n_send - s0 != 1 || n_done[2] - d0 != 0 || n_fail[2] - f0 != 0) begin
         errors++;
         $display("FAIL rmid_counts: sends=%0d done=%0d fail=%0d, expected 1/0/0", n_send - s0, n_done[2] - d0, n_fail[2] - f0);
      end
   endtask

   initial begin
      req                = '0;
      req_type           = '0;
      req_payload        = '0;
      link.message_acked = 1'b0;
      test_reset();
      test_single_no_ack();
      do_reset();
      test_simultaneous();
      test_ack_arrives();
      test_no_ack();
      test_stale_ack();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
